pwm_multi_generator: RTL and testbench

Parametrised multi-channel PWM generator that supersedes the single-channel `pwm_generator`. It contains a shared prescaler and period counter, and per-channel double-buffered duty registers that update glitch-free at period boundaries. An optional center-aligned counting mode is compiled in by macro. It sits between the control/register logic that supplies duty values and the pin-level outputs driving the power stage or LEDs.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_prescaler.sv | 36 +++
 rtl/pwm_multi_generator.sv | 145 ++++++++++++++
 tb/tb_pwm_multi_generator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_RES_BITS = 16;

    typedef logic [MAX_RES_BITS-1:0] cnt_word_t;

    // Counting direction, only meaningful in the center-aligned build.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic cnt_word_t cnt_max(input int unsigned res_bits);
        return cnt_word_t'((32'd1 << res_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM period counter: one tick every max(t_lsb,1) clocks.
module pwm_prescaler #(
    parameter int PRESC_BITS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [PRESC_BITS-1:0] t_lsb,
    output logic                  tick
);

    logic [PRESC_BITS-1:0] presc_reg;
    logic [PRESC_BITS-1:0] presc_limit;

    // Comparing with >= means a shrinking t_lsb fires on the next clock
    // instead of wrapping the whole counter range.
    always_comb begin
        presc_limit = '0;
        if (t_lsb != '0) begin
            presc_limit = t_lsb - PRESC_BITS'(1);
        end
    end

    assign tick = !hold && (presc_reg >= presc_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (hold || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM with shared prescaler/period counter and double-buffered duties.
// Define PWM_CENTER_ALIGN_EN to build the up/down (center-aligned) counter.
module pwm_multi_generator
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int RES_BITS   = 10,
    parameter int PRESC_BITS = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_signal,
    input  logic [CHANNELS*RES_BITS-1:0] pwm_value,
    input  logic                         load_strobe,
    input  logic [PRESC_BITS-1:0]        t_lsb,
    output logic [CHANNELS-1:0]          pwm_signal,
    output logic                         period_start
);

    localparam cnt_word_t            CNT_MAX_W = cnt_max(RES_BITS);
    localparam logic [RES_BITS-1:0]  CNT_MAX   = CNT_MAX_W[RES_BITS-1:0];

    logic                tick;
    logic                boundary;
    logic [RES_BITS-1:0] cnt_reg;
    logic                pending_reg;
    logic                restart_reg;
    logic                period_start_reg;

    pwm_prescaler #(
        .PRESC_BITS (PRESC_BITS)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .hold  (sync_signal),
        .t_lsb (t_lsb),
        .tick  (tick)
    );

`ifdef PWM_CENTER_ALIGN_EN
    dir_e dir_reg;

    // The period closes on the down-count step from 1 back to 0.
    assign boundary = tick && (dir_reg == DIR_DOWN) && (cnt_reg == RES_BITS'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            dir_reg <= DIR_UP;
        end else if (sync_signal) begin
            cnt_reg <= '0;
            dir_reg <= DIR_UP;
        end else if (tick) begin
            if (dir_reg == DIR_UP) begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_reg <= CNT_MAX - RES_BITS'(1);
                    dir_reg <= DIR_DOWN;
                end else begin
                    cnt_reg <= cnt_reg + RES_BITS'(1);
                end
            end else begin
                if (cnt_reg == RES_BITS'(1)) begin
                    cnt_reg <= '0;
                    dir_reg <= DIR_UP;
                end else begin
                    cnt_reg <= cnt_reg - RES_BITS'(1);
                end
            end
        end
    end
`else
    assign boundary = tick && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (sync_signal) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= cnt_reg + RES_BITS'(1);
        end
    end
`endif

    // restart_reg marks the first tick after a sync release so it also
    // announces a period start even though no boundary preceded it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg      <= 1'b0;
            restart_reg      <= 1'b0;
            period_start_reg <= 1'b0;
        end else if (sync_signal) begin
            pending_reg      <= 1'b0;
            restart_reg      <= 1'b1;
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= tick && (boundary || restart_reg);
            if (tick) begin
                restart_reg <= 1'b0;
            end
            if (boundary) begin
                pending_reg <= 1'b0;
            end else if (load_strobe) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign period_start = period_start_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [RES_BITS-1:0] duty_in;
        logic [RES_BITS-1:0] shadow_reg;
        logic [RES_BITS-1:0] active_reg;
        logic                pwm_bit_reg;

        assign duty_in = pwm_value[gi*RES_BITS +: RES_BITS];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_reg  <= '0;
                active_reg  <= '0;
                pwm_bit_reg <= 1'b0;
            end else if (sync_signal) begin
                shadow_reg  <= duty_in;
                active_reg  <= duty_in;
                pwm_bit_reg <= 1'b0;
            end else begin
                if (load_strobe) begin
                    shadow_reg <= duty_in;
                end
                // A load landing on the boundary bypasses the shadow stage.
                if (boundary && load_strobe) begin
                    active_reg <= duty_in;
                end else if (boundary && pending_reg) begin
                    active_reg <= shadow_reg;
                end
                pwm_bit_reg <= (cnt_reg < active_reg);
            end
        end

        assign pwm_signal[gi] = pwm_bit_reg;
    end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Self-checking bench for pwm_multi_generator (4 channels, 4-bit resolution).
// Window measurements between period_start pulses are scored against expected records.
module tb_pwm_multi_generator;

    localparam int CH = 4;
    localparam int RB = 4;
    localparam int PB = 12;

    logic              clk;
    logic              reset;
    logic              sync_signal;
    logic [CH*RB-1:0]  pwm_value;
    logic              load_strobe;
    logic [PB-1:0]     t_lsb;
    logic [CH-1:0]     pwm_signal;
    logic              period_start;

    pwm_multi_generator #(
        .CHANNELS   (CH),
        .RES_BITS   (RB),
        .PRESC_BITS (PB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sync_signal  (sync_signal),
        .pwm_value    (pwm_value),
        .load_strobe  (load_strobe),
        .t_lsb        (t_lsb),
        .pwm_signal   (pwm_signal),
        .period_start (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int len;
        int high [CH];
    } win_t;

    typedef struct {
        int t;
        int duty [CH];
        int len;
        int high [CH];
    } vec_t;

    win_t meas_q [$];
    win_t exp_q  [$];
    vec_t vecs   [5];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Monitor: one record per full window between consecutive period_start pulses.
    initial begin
        win_t cur;
        bit   win_active;
        win_active = 1'b0;
        cur.len = 0;
        for (int i = 0; i < CH; i++) cur.high[i] = 0;
        forever begin
            @(negedge clk);
            if (reset || sync_signal) begin
                win_active = 1'b0;
            end else begin
                if (period_start) begin
                    if (win_active) meas_q.push_back(cur);
                    cur.len = 0;
                    for (int i = 0; i < CH; i++) cur.high[i] = 0;
                    win_active = 1'b1;
                end
                if (win_active) begin
                    cur.len++;
                    for (int i = 0; i < CH; i++) cur.high[i] += int'(pwm_signal[i]);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_duties(input int d0, input int d1, input int d2, input int d3);
        pwm_value = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    endtask

    task automatic push_exp(input int len, input int h0, input int h1, input int h2, input int h3);
        win_t w;
        w.len = len;
        w.high[0] = h0; w.high[1] = h1; w.high[2] = h2; w.high[3] = h3;
        exp_q.push_back(w);
    endtask

    // Holds sync with the given duties, then releases it just after a rising edge.
    task automatic sync_load(input int t, input int d0, input int d1, input int d2, input int d3);
        @(posedge clk); #1;
        sync_signal = 1'b1;
        load_strobe = 1'b0;
        t_lsb = PB'(t);
        set_duties(d0, d1, d2, d3);
        repeat (3) @(posedge clk);
        #1;
        meas_q.delete();
        exp_q.delete();
        sync_signal = 1'b0;
    endtask

    task automatic wait_meas(input int n);
        int c = 0;
        while (meas_q.size() < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
    endtask

    task automatic compare_window(input string tag, input int idx);
        win_t e;
        win_t m;
        e = exp_q.pop_front();
        check({tag, "_window_seen"}, (meas_q.size() > idx) ? 1 : 0, 1);
        if (meas_q.size() > idx) begin
            m = meas_q[idx];
            check({tag, "_len"}, m.len, e.len);
            for (int i = 0; i < CH; i++)
                check($sformatf("%s_high_ch%0d", tag, i), m.high[i], e.high[i]);
        end
    endtask

    task automatic pulse_load(input int d0, input int d1, input int d2, input int d3);
        set_duties(d0, d1, d2, d3);
        load_strobe = 1'b1;
        @(posedge clk); #1;
        load_strobe = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        reset       = 1'b1;
        sync_signal = 1'b1;
        load_strobe = 1'b0;
        pwm_value   = '0;
        t_lsb       = PB'(1);

`ifdef PWM_CENTER_ALIGN_EN
        vecs[0] = '{1, '{0, 15, 8, 1}, 30, '{0, 29, 15, 1}};
        vecs[1] = '{0, '{0, 15, 8, 1}, 30, '{0, 29, 15, 1}};
        vecs[2] = '{2, '{5, 0, 3, 15}, 60, '{18, 0, 10, 58}};
        vecs[3] = '{3, '{1, 2, 4, 7},  90, '{3, 9, 21, 39}};
        vecs[4] = '{1, '{4, 4, 0, 15}, 30, '{7, 7, 0, 29}};
`else
        vecs[0] = '{1, '{0, 15, 8, 1}, 16, '{0, 15, 8, 1}};
        vecs[1] = '{0, '{0, 15, 8, 1}, 16, '{0, 15, 8, 1}};
        vecs[2] = '{2, '{5, 0, 3, 15}, 32, '{10, 0, 6, 30}};
        vecs[3] = '{3, '{1, 2, 4, 7},  48, '{3, 6, 12, 21}};
        vecs[4] = '{1, '{4, 4, 0, 15}, 16, '{4, 4, 0, 15}};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pwm_signal", int'(pwm_signal), 0);
        check("reset_period_start", int'(period_start), 0);

        // Sync with zero duties, then sync with full duties plus loads: outputs stay low.
        @(posedge clk); #1;
        reset = 1'b0;
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            acc += int'(pwm_signal != '0) + int'(period_start);
        end
        check("sync_zero_outputs", acc, 0);
        @(posedge clk); #1;
        set_duties(15, 15, 15, 15);
        load_strobe = 1'b1;
        acc = 0;
        repeat (10) begin
            @(negedge clk);
            acc += int'(pwm_signal != '0) + int'(period_start);
        end
        load_strobe = 1'b0;
        check("sync_override_outputs", acc, 0);

        // Table: duties applied through sync, second window after release is steady state.
        for (int v = 0; v < 5; v++) begin
            sync_load(vecs[v].t, vecs[v].duty[0], vecs[v].duty[1], vecs[v].duty[2], vecs[v].duty[3]);
            push_exp(vecs[v].len, vecs[v].high[0], vecs[v].high[1], vecs[v].high[2], vecs[v].high[3]);
            wait_meas(2);
            compare_window($sformatf("vec%0d", v), 1);
            $display("vector %0d t_lsb=%0d done", v, vecs[v].t);
        end

        // New duty takes effect only at the next period start.
        sync_load(2, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        pulse_load(5, 0, 0, 0);
        wait_meas(3);
        check("latency_old_period_ch0", (meas_q.size() > 0) ? meas_q[0].high[0] : -1, 0);
`ifdef PWM_CENTER_ALIGN_EN
        check("latency_first_period_ch0", (meas_q.size() > 1) ? meas_q[1].high[0] : -1, 17);
        push_exp(60, 18, 0, 0, 0);
`else
        check("latency_first_period_ch0", (meas_q.size() > 1) ? meas_q[1].high[0] : -1, 10);
        push_exp(32, 10, 0, 0, 0);
`endif
        compare_window("latency_steady", 2);
        $display("load latency sequence done");

`ifndef PWM_CENTER_ALIGN_EN
        // Mid-period load at cnt=5: current period keeps 8, next gets 3.
        sync_load(1, 8, 0, 0, 0);
        push_exp(16, 8, 0, 0, 0);
        push_exp(16, 3, 0, 0, 0);
        wait_meas(1);
        repeat (4) @(posedge clk);
        #1;
        pulse_load(3, 0, 0, 0);
        wait_meas(3);
        compare_window("glitch_cur", 1);
        compare_window("glitch_next", 2);
        $display("mid-period load sequence done");

        // Load on the boundary cycle (cnt=15) applies to the very next period.
        sync_load(1, 8, 0, 0, 0);
        push_exp(16, 8, 0, 0, 0);
        push_exp(16, 3, 0, 0, 0);
        wait_meas(1);
        repeat (14) @(posedge clk);
        #1;
        pulse_load(3, 0, 0, 0);
        wait_meas(3);
        compare_window("coincide_cur", 1);
        compare_window("coincide_next", 2);
        $display("boundary load sequence done");

        // t_lsb 10 -> 3 while presc=7: tick on that clock, no counter overrun.
        sync_load(10, 1, 2, 15, 0);
        push_exp(53, 8, 11, 50, 0);
        push_exp(48, 3, 6, 45, 0);
        wait_meas(1);
        repeat (6) @(posedge clk);
        #1;
        t_lsb = PB'(3);
        wait_meas(3);
        compare_window("tlsb_change", 1);
        compare_window("tlsb_after", 2);
        $display("t_lsb decrease sequence done");
`endif

        // Asynchronous reset mid-period, then counting resumes from 0 with duties 0.
        sync_load(1, 15, 15, 15, 15);
        wait_meas(1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_pwm_low", int'(pwm_signal), 0);
        check("async_reset_period_start_low", int'(period_start), 0);
        @(posedge clk); #1;
        meas_q.delete();
        exp_q.delete();
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (!period_start && n < 200) begin
            n++;
            @(negedge clk);
        end
`ifdef PWM_CENTER_ALIGN_EN
        check("reset_resume_first_period_start", n, 30);
        push_exp(30, 0, 0, 0, 0);
`else
        check("reset_resume_first_period_start", n, 16);
        push_exp(16, 0, 0, 0, 0);
`endif
        wait_meas(1);
        compare_window("reset_resume", 0);
        $display("reset mid-period sequence done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
